// File: rtl/multicycle_control.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with a
// memory-wait timeout, sticky fault flags and a saturating retired-instruction counter.
module multicycle_control #(
  parameter int OPW     = 3,   // must be >= 3
  parameter int CNTW    = 16,
  parameter int TIMEOUT = 15   // must be >= 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OPW-1:0]  op,
  input  logic            mem_ready,
  input  logic            zero,
  output logic            sigPCWrite,
  output logic            sigIRWrite,
  output logic            sigBranch,
  output logic            sigMemtoReg,
  output logic            sigMemRead,
  output logic            sigMemWrite,
  output logic            sigALUSrc,
  output logic            sigRegWrite,
  output logic            sigRegDst,
  output logic [1:0]      sigALUOp,
  output logic [2:0]      state,
  output logic            halted,
  output logic            illegal,
  output logic            bus_fault,
  output logic [CNTW-1:0] instr_count
);
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] OP_ALUR   = 3'd0;
  localparam logic [2:0] OP_LOAD   = 3'd1;
  localparam logic [2:0] OP_STORE  = 3'd2;
  localparam logic [2:0] OP_BRANCH = 3'd3;
  localparam logic [2:0] OP_ADDI   = 3'd4;
  localparam logic [2:0] OP_HALT   = 3'd7;

  // The wait counter never exceeds TIMEOUT-1 before the fault fires.
  localparam int              WAITW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAITW-1:0] WAIT_LAST = WAITW'(TIMEOUT - 1);

  state_t            state_q;
  logic [2:0]        op_q;
  logic [WAITW-1:0]  wait_q;
  logic [CNTW-1:0]   count_q;
  logic [CNTW-1:0]   count_d;
  logic              halted_q;
  logic              illegal_q;
  logic              bus_fault_q;

  logic [2:0]        op_lo;
  logic              op_hi_zero;
  logic              op_legal;
  logic              timeout_hit;

  assign op_lo = op[2:0];

  generate
    if (OPW > 3) begin : g_op_hi
      assign op_hi_zero = ~|op[OPW-1:3];
    end else begin : g_op_nohi
      assign op_hi_zero = 1'b1;
    end
  endgenerate

  assign op_legal    = op_hi_zero &&
                       (op_lo inside {OP_ALUR, OP_LOAD, OP_STORE, OP_BRANCH, OP_ADDI, OP_HALT});
  assign timeout_hit = !mem_ready && (wait_q == WAIT_LAST);
  assign count_d     = (&count_q) ? count_q : count_q + CNTW'(1);

  // Wait counter is zero on every entry to FETCH/MEM because every exit clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      op_q        <= '0;
      wait_q      <= '0;
      count_q     <= '0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      bus_fault_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready) begin
            wait_q  <= '0;
            state_q <= S_DECODE;
          end else if (timeout_hit) begin
            bus_fault_q <= 1'b1;
            halted_q    <= 1'b1;
            state_q     <= S_HALT;
          end else begin
            wait_q <= wait_q + WAITW'(1);
          end
        end
        S_DECODE: begin
          op_q <= op_lo;
          if (!op_legal) begin
            illegal_q <= 1'b1;
            state_q   <= S_FETCH;
          end else if (op_lo == OP_HALT) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_BRANCH: begin
              state_q <= S_FETCH;
              count_q <= count_d;
            end
            OP_LOAD, OP_STORE: state_q <= S_MEM;
            default:           state_q <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            wait_q <= '0;
            if (op_q == OP_LOAD) begin
              state_q <= S_WB;
            end else begin
              state_q <= S_FETCH;
              count_q <= count_d;
            end
          end else if (timeout_hit) begin
            bus_fault_q <= 1'b1;
            halted_q    <= 1'b1;
            state_q     <= S_HALT;
          end else begin
            wait_q <= wait_q + WAITW'(1);
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
          count_q <= count_d;
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Controls are Moore on (state, op_q) except the mem_ready/zero gated strobes,
  // and are forced low while reset is held.
  always_comb begin
    sigPCWrite  = 1'b0;
    sigIRWrite  = 1'b0;
    sigBranch   = 1'b0;
    sigMemtoReg = 1'b0;
    sigMemRead  = 1'b0;
    sigMemWrite = 1'b0;
    sigALUSrc   = 1'b0;
    sigRegWrite = 1'b0;
    sigRegDst   = 1'b0;
    sigALUOp    = 2'b00;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          sigMemRead = 1'b1;
          sigIRWrite = mem_ready;
          sigPCWrite = mem_ready;
        end
        S_EXEC: begin
          case (op_q)
            OP_ALUR: sigALUOp = 2'b10;
            OP_ADDI, OP_LOAD, OP_STORE: sigALUSrc = 1'b1;
            OP_BRANCH: begin
              sigBranch  = 1'b1;
              sigALUOp   = 2'b01;
              sigPCWrite = zero;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          sigMemRead  = (op_q == OP_LOAD);
          sigMemWrite = (op_q == OP_STORE);
        end
        S_WB: begin
          sigRegWrite = 1'b1;
          sigMemtoReg = (op_q == OP_LOAD);
          sigRegDst   = (op_q == OP_ALUR);
        end
        default: ;
      endcase
    end
  end

  assign state       = state_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;
  assign bus_fault   = bus_fault_q;
  assign instr_count = count_q;
endmodule
